memdata_arbiter: RTL and testbench
==================================

// Module: memdata_arbiter
// PURPOSE
// - Shares the single data-memory interface (memData_interface) between two requesters: port 0 = core load/store unit, port 1 = debug/DMA.
// - Valid/ready request handshake per port, one access in flight; read data and write ack routed back to the issuing port.
// - Sits between the execute stage / debug unit and memData_interface; it is the only driver of that interface.
// PARAMETERS
// - XLEN  32  address/data width; matches memData_interface XLEN
// PORTS
// - clk                  in   1     core clock
// - reset_n              in   1     asynchronous active-low reset
// - req0_valid           in   1     port 0 request present
// - req0_ready           out  1     port 0 request accepted this cycle (valid & ready)
// - req0_we              in   1     1 = write, 0 = read
// - req0_addr            in   XLEN  byte address
// - req0_wdata           in   XLEN  write data
// - rsp0_valid           out  1     one-cycle pulse: port 0 access complete
// - rsp0_rdata           out  XLEN  read data (0 for writes), valid with rsp0_valid
// - req1_* / rsp1_*      same set as port 0, for port 1
// - mem_read_address     out  XLEN  to memData_interface read_address
// - mem_write_address    out  XLEN  to memData_interface write_address
// - mem_data_write       out  XLEN  to memData_interface data_write
// - mem_write_enabled    out  1     to memData_interface write_enabled
// - mem_data_out         in   XLEN  from memData_interface data_out
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, all outputs 0, last_grant=1 (port 0 wins first contest). Reset mid-access aborts it: no rsp pulse, no write.
// - FSM: IDLE -> ISSUE on any accepted request; ISSUE -> RESP always; RESP -> ISSUE if a request is accepted in RESP, else IDLE.
// - reqN_ready is high only in IDLE or RESP, only for the granted port, and only while reqN_valid; at most one ready per cycle.
// - Accept cycle T: addr/wdata/we/owner captured into registers. Cycle T+1 (ISSUE): mem_read_address = mem_write_address = captured addr,
//   mem_data_write = wdata, mem_write_enabled = we; memory reads at negedge, mem_data_out sampled at end of T+1.
// - Cycle T+2 (RESP): rspN_valid=1 for owner only, rspN_rdata = sampled data (reads) or 0 (writes). Latency accept->rsp = 2 cycles; peak throughput 1 access / 2 cycles.
// - mem_write_enabled is 1 only in ISSUE with we=1; outside ISSUE mem_* hold last values with write_enabled=0.
// - Arbitration: single requester wins immediately; both valid -> grant port != last_grant; last_grant updates on every accept.
// - Responses have no back-pressure; requester must accept rsp pulse. Requester may drop valid before ready without side effect.
// - Addresses passed unmodified (no alignment check, no wrap handling); full XLEN widths, no arithmetic.
// CONFIGURATION
// - MEMARB_FIXED_PRIO_EN defined: port 0 always wins contention; last_grant unused; port 1 may starve.
// - Not defined (default): two-way round-robin as above; no port waits more than one access when both stream.
// STRUCTURE
// - Shared header memarb_defs.vh: FSM state localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2; port-id constants PORT_LSU=1'b0, PORT_DBG=1'b1.
// - One sub-module rr_arbiter_2: inputs req[1:0], last_grant, enable; output one-hot gnt[1:0]; holds the macro-selected priority logic.
// - Top holds FSM, capture registers, response demux.
// TESTING
// - Reset: reset_n=0 for 3 cycles with both valids high -> all outputs 0, no ready, no mem write; first accept after release goes to port 0.
// - Port 0 write 0x0000_0040 <= 0xDEAD_BEEF, then read 0x40 -> write: mem_write_enabled=1 exactly one cycle, rsp0 at T+2 rdata=0; read: rsp0_rdata=0xDEAD_BEEF at T+2.
// - Both valid continuously, 6 reads each -> grants alternate 0,1,0,1...; rsp pulses every 2 cycles alternating ports; zero rsp on wrong port.
// - Same contention with MEMARB_FIXED_PRIO_EN -> all 6 port 0 accesses first, port 1 only after req0_valid drops.
// - reset_n asserted in ISSUE of a write to 0x80 with 0x1234 -> later read of 0x80 returns prior value; no rsp pulse after reset.
// - Request in RESP cycle -> back-to-back: ready in RESP, next ISSUE immediately following; write-then-read same address returns new data.

Source files
------------

// File: rtl/memdata_arbiter_pkg.sv
// Shared definitions for memdata_arbiter: FSM states, port ids, default width.
package memdata_arbiter_pkg;

  localparam int unsigned MEMARB_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } memarb_state_e;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/memdata_arbiter_rr.sv
// Two-requester grant logic. Build option MEMARB_FIXED_PRIO_EN selects
// fixed priority (port 0 always wins); default is two-way round-robin.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

`ifdef MEMARB_FIXED_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  // Port 0 always takes precedence over port 1.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  // Lone requester wins at once; on contention the port not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end
`endif

endmodule

// File: rtl/memdata_arbiter.sv
// Shares the data-memory interface between the LSU (port 0) and debug/DMA
// (port 1). One access in flight: accept -> ISSUE -> RESP, rsp 2 cycles after
// accept. Option macro MEMARB_FIXED_PRIO_EN (see rr_arbiter_2).
module memdata_arbiter
  import memdata_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = MEMARB_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_we,
  input  logic [XLEN-1:0] req0_addr,
  input  logic [XLEN-1:0] req0_wdata,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_rdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_we,
  input  logic [XLEN-1:0] req1_addr,
  input  logic [XLEN-1:0] req1_wdata,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_rdata,
  output logic [XLEN-1:0] mem_read_address,
  output logic [XLEN-1:0] mem_write_address,
  output logic [XLEN-1:0] mem_data_write,
  output logic            mem_write_enabled,
  input  logic [XLEN-1:0] mem_data_out
);

  memarb_state_e   r_state;
  memarb_state_e   w_state_nxt;
  logic            r_active;
  logic            r_last_grant;
  logic            r_owner;
  logic            r_we;
  logic            w_arb_en;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic            w_sel;
  logic            w_sel_we;
  logic [XLEN-1:0] w_sel_addr;
  logic [XLEN-1:0] w_sel_wdata;

  // Grants only in IDLE/RESP, and not in the first cycle after reset release.
  assign w_arb_en = r_active && ((r_state == ST_IDLE) || (r_state == ST_RESP));

  rr_arbiter_2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .gnt        (w_gnt)
  );

  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign w_accept    = |w_gnt;
  assign w_sel       = w_gnt[1];
  assign w_sel_we    = w_sel ? req1_we    : req0_we;
  assign w_sel_addr  = w_sel ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_sel ? req1_wdata : req0_wdata;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture on accept, drive memory during ISSUE, return response in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active          <= 1'b0;
      r_last_grant      <= PORT_DBG;
      r_owner           <= PORT_LSU;
      r_we              <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_data_write    <= '0;
      mem_write_enabled <= 1'b0;
      rsp0_valid        <= 1'b0;
      rsp0_rdata        <= '0;
      rsp1_valid        <= 1'b0;
      rsp1_rdata        <= '0;
    end else begin
      r_active          <= 1'b1;
      mem_write_enabled <= 1'b0;
      rsp0_valid        <= 1'b0;
      rsp1_valid        <= 1'b0;
      if (w_accept) begin
        r_last_grant      <= w_sel;
        r_owner           <= w_sel;
        r_we              <= w_sel_we;
        mem_read_address  <= w_sel_addr;
        mem_write_address <= w_sel_addr;
        mem_data_write    <= w_sel_wdata;
        mem_write_enabled <= w_sel_we;
      end
      if (r_state == ST_ISSUE) begin
        if (r_owner == PORT_LSU) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= r_we ? '0 : mem_data_out;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= r_we ? '0 : mem_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_memdata_arbiter.sv
// Scoreboard bench for memdata_arbiter with a behavioural data memory.
module tb_memdata_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v   [2];
  logic        w   [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_read_address, mem_write_address, mem_data_write, mem_data_out;
  logic        mem_write_enabled;

  memdata_arbiter #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(w[0]),
    .req0_addr(ad[0]), .req0_wdata(wd[0]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(w[1]),
    .req1_addr(ad[1]), .req1_wdata(wd[1]),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_data_write(mem_data_write), .mem_write_enabled(mem_write_enabled),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          t;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          glog[$];
  int          gcyc[$];
  logic [31:0] mem_env [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          we_hi = 0;
  int          last_acc = 0;
  logic [31:0] la_addr = '0;
  logic [31:0] la_wd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    if (mem_env.exists(a)) return mem_env[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Data memory: writes at posedge, read data presented at negedge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enabled) mem_env[mem_write_address] = mem_data_write;
  end
  always @(negedge clk) mem_data_out = env_rd(mem_read_address);

  task automatic accept(input int p);
    exp_t e;
    glog.push_back(p);
    gcyc.push_back(cyc);
    last_acc = cyc;
    la_addr  = ad[p];
    la_wd    = wd[p];
    e.t      = cyc + 2;
    if (w[p]) begin
      e.d = '0;
      ref_mem[ad[p]] = wd[p];
    end else begin
      e.d = ref_rd(ad[p]);
    end
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: record accepts, check memory drive and responses.
  always @(negedge clk) begin
    exp_t e;
    if (req0_ready || req1_ready) chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
    if (v[0] && req0_ready) accept(0);
    if (v[1] && req1_ready) accept(1);
    if (mem_write_enabled) begin
      we_hi++;
      chk("wr_addr", mem_write_address, la_addr);
      chk("wr_data", mem_data_write, la_wd);
      chk("rd_eq_wr_addr", mem_read_address, mem_write_address);
    end
    if (rsp0_valid) begin
      if (q0.size() == 0) chk("rsp0_spurious", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rsp0_data", rsp0_rdata, e.d);
        chk("rsp0_lat", 32'(cyc), 32'(e.t));
      end
    end
    if (rsp1_valid) begin
      if (q1.size() == 0) chk("rsp1_spurious", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_data", rsp1_rdata, e.d);
        chk("rsp1_lat", 32'(cyc), 32'(e.t));
      end
    end
  end

  task automatic issue(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    int n;
    v[p] = 1'b1; w[p] = we; ad[p] = a; wd[p] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((p == 0) ? req0_ready : req1_ready) && n < 80);
    if (!((p == 0) ? req0_ready : req1_ready)) chk("accept_timeout", 32'(p), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    if (!hold) v[p] = 1'b0;
  endtask

  task automatic stream(input int p, input logic [31:0] base);
    for (int i = 0; i < 6; i++) issue(p, 1'b0, base + 32'(4 * i), 32'd0, i < 5);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0)
      chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          we0;
    int          t0;
    logic [31:0] expg;

    // Reset held with both requesters valid.
    reset_n = 1'b0;
    v[0] = 1'b1; w[0] = 1'b0; ad[0] = 32'h100; wd[0] = '0;
    v[1] = 1'b1; w[1] = 1'b0; ad[1] = 32'h200; wd[1] = '0;
    mem_data_out = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy0", 32'(req0_ready), 32'd0);
      chk("rst_rdy1", 32'(req1_ready), 32'd0);
      chk("rst_we", 32'(mem_write_enabled), 32'd0);
      chk("rst_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      chk("rst_addr", mem_read_address, 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Contention: both stream 6 reads.
    fork
      stream(0, 32'h100);
      stream(1, 32'h200);
    join
    wait_idle();
    chk("grant_count", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12 && i < glog.size(); i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
      expg = (i < 6) ? 32'd0 : 32'd1;
`else
      expg = 32'(i % 2);
`endif
      chk("grant_order", 32'(glog[i]), expg);
      if (i > 0) chk("grant_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end

    // Port 0 write then read of 0x40.
    we0 = we_hi;
    issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 32'h0000_0040, 32'd0, 1'b0);
    wait_idle();
    chk("we_cycles", 32'(we_hi - we0), 32'd1);

    // Reset during ISSUE of a write aborts it.
    issue(1, 1'b1, 32'h80, 32'h5555_AAAA, 1'b0);
    wait_idle();
    issue(0, 1'b1, 32'h80, 32'h0000_1234, 1'b0);
    chk("abort_we_issue", 32'(mem_write_enabled), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_we_cleared", 32'(mem_write_enabled), 32'd0);
    q0.delete();
    q1.delete();
    ref_mem[32'h80] = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(0, 1'b0, 32'h80, 32'd0, 1'b0);
    wait_idle();

    // Back-to-back: accept in RESP, write then read of same address.
    issue(1, 1'b1, 32'h300, 32'hCAFE_F00D, 1'b1);
    t0 = last_acc;
    issue(1, 1'b0, 32'h300, 32'd0, 1'b0);
    chk("b2b_gap", 32'(last_acc - t0), 32'd2);
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
